// File: rtl/lc3b_types.sv
// Shared LC-3b types plus the scoreboard counter width and condition-code reset value.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_reg;
    typedef logic [2:0]  lc3b_nzp;

    localparam int      SB_CNT_W = 2;
    localparam lc3b_nzp CC_RESET = 3'b010;

    typedef logic [SB_CNT_W-1:0] sb_cnt_t;

    localparam sb_cnt_t SB_CNT_ZERO = {SB_CNT_W{1'b0}};
    localparam sb_cnt_t SB_CNT_ONE  = {{(SB_CNT_W-1){1'b0}}, 1'b1};
    localparam sb_cnt_t SB_CNT_MAX  = {SB_CNT_W{1'b1}};

    // Pending count as seen by a reader once this cycle's commit retires one writer.
    function automatic sb_cnt_t eff_cnt(input sb_cnt_t cnt, input logic committing);
        if (committing && (cnt != SB_CNT_ZERO)) begin
            return cnt - SB_CNT_ONE;
        end else begin
            return cnt;
        end
    endfunction

endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// Saturating up/down pending-writer counter; flags a decrement that finds it empty.
module sb_counter
    import lc3b_types::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    inc_i,
    input  logic    dec_i,
    output sb_cnt_t cnt_o,
    output logic    underflow_o
);

    sb_cnt_t cnt_q;
    sb_cnt_t cnt_d;

    // Next count: a paired inc/dec cancels, and both ends saturate.
    always_comb begin
        cnt_d = cnt_q;
        case ({inc_i, dec_i})
            2'b10: begin
                if (cnt_q != SB_CNT_MAX) cnt_d = cnt_q + SB_CNT_ONE;
                else                     cnt_d = cnt_q;
            end
            2'b01: begin
                if (cnt_q != SB_CNT_ZERO) cnt_d = cnt_q - SB_CNT_ONE;
                else                      cnt_d = cnt_q;
            end
            default: cnt_d = cnt_q;
        endcase
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= SB_CNT_ZERO;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o       = cnt_q;
    assign underflow_o = dec_i & (cnt_q == SB_CNT_ZERO);

endmodule

// File: rtl/regfile_scoreboard.sv
// LC-3b register file and condition code with write-back bypass and a per-register
// pending-writer scoreboard that stalls decode on RAW hazards or counter saturation.
module regfile_scoreboard
    import lc3b_types::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     dec_valid,
    input  lc3b_reg  dec_sr1,
    input  lc3b_reg  dec_sr2,
    input  logic     dec_use_sr1,
    input  logic     dec_use_sr2,
    input  lc3b_reg  dec_dr,
    input  logic     dec_ld_reg,
    input  logic     dec_ld_cc,
    input  logic     dec_use_cc,
    input  logic     wb_valid,
    input  lc3b_reg  wb_dest_reg,
    input  lc3b_word wb_reg_data,
    input  logic     wb_ld_reg,
    input  logic     wb_ld_cc,
    input  lc3b_nzp  wb_nzp,
    output lc3b_word sr1_data,
    output lc3b_word sr2_data,
    output lc3b_nzp  nzp_out,
    output logic     dec_stall,
    output logic     issue,
    output logic     sb_err
);

    lc3b_word   regs_q [8];
    lc3b_nzp    cc_q;
    logic       sb_err_q;
    logic       sb_err_d;

    sb_cnt_t    reg_cnt_s [8];
    logic [7:0] reg_inc_s;
    logic [7:0] reg_dec_s;
    logic [7:0] reg_uf_s;
    sb_cnt_t    cc_cnt_s;
    logic       cc_uf_s;
    logic       wb_reg_s;
    logic       wb_cc_s;
    logic       hazard_s;

    assign wb_reg_s = wb_valid & wb_ld_reg;
    assign wb_cc_s  = wb_valid & wb_ld_cc;

    for (genvar g = 0; g < 8; g++) begin : g_reg_cnt
        assign reg_inc_s[g] = issue & dec_ld_reg & (dec_dr == lc3b_reg'(g));
        assign reg_dec_s[g] = wb_reg_s & (wb_dest_reg == lc3b_reg'(g));

        sb_counter u_cnt (
            .clk         (clk),
            .rst_n       (rst_n),
            .inc_i       (reg_inc_s[g]),
            .dec_i       (reg_dec_s[g]),
            .cnt_o       (reg_cnt_s[g]),
            .underflow_o (reg_uf_s[g])
        );
    end

    sb_counter u_cc_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc_i       (issue & dec_ld_cc),
        .dec_i       (wb_cc_s),
        .cnt_o       (cc_cnt_s),
        .underflow_o (cc_uf_s)
    );

    // Operand reads with same-cycle write-back bypass.
    always_comb begin
        if (wb_reg_s && (wb_dest_reg == dec_sr1)) sr1_data = wb_reg_data;
        else                                      sr1_data = regs_q[dec_sr1];
        if (wb_reg_s && (wb_dest_reg == dec_sr2)) sr2_data = wb_reg_data;
        else                                      sr2_data = regs_q[dec_sr2];
        if (wb_cc_s) nzp_out = wb_nzp;
        else         nzp_out = cc_q;
    end

    // Hazards: readers see the post-commit count; writers are blocked only by a full counter.
    always_comb begin
        hazard_s = 1'b0;
        if (dec_use_sr1 &&
            (eff_cnt(reg_cnt_s[dec_sr1], wb_reg_s && (wb_dest_reg == dec_sr1)) != SB_CNT_ZERO))
            hazard_s = 1'b1;
        else if (dec_use_sr2 &&
            (eff_cnt(reg_cnt_s[dec_sr2], wb_reg_s && (wb_dest_reg == dec_sr2)) != SB_CNT_ZERO))
            hazard_s = 1'b1;
        else if (dec_use_cc && (eff_cnt(cc_cnt_s, wb_cc_s) != SB_CNT_ZERO))
            hazard_s = 1'b1;
        else if (dec_ld_reg && (reg_cnt_s[dec_dr] == SB_CNT_MAX))
            hazard_s = 1'b1;
        else if (dec_ld_cc && (cc_cnt_s == SB_CNT_MAX))
            hazard_s = 1'b1;
        else
            hazard_s = 1'b0;
    end

    assign dec_stall = dec_valid & hazard_s;
    assign issue     = dec_valid & ~hazard_s;
    assign sb_err_d  = sb_err_q | (|reg_uf_s) | cc_uf_s;

    // Architectural state and the sticky underflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= 16'h0000;
            cc_q     <= CC_RESET;
            sb_err_q <= 1'b0;
        end else begin
            if (wb_reg_s) regs_q[wb_dest_reg] <= wb_reg_data;
            if (wb_cc_s)  cc_q <= wb_nzp;
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err = sb_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed literal checks plus randomized pipeline traffic against a behavioural
// register-file/scoreboard model compared on every falling edge.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        dec_valid, dec_use_sr1, dec_use_sr2, dec_ld_reg, dec_ld_cc, dec_use_cc;
    logic [2:0]  dec_sr1, dec_sr2, dec_dr;
    logic        wb_valid, wb_ld_reg, wb_ld_cc;
    logic [2:0]  wb_dest_reg, wb_nzp;
    logic [15:0] wb_reg_data;
    logic [15:0] sr1_data, sr2_data;
    logic [2:0]  nzp_out;
    logic        dec_stall, issue, sb_err;

    int checks   = 0;
    int failures = 0;

    regfile_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .dec_valid(dec_valid), .dec_sr1(dec_sr1), .dec_sr2(dec_sr2),
        .dec_use_sr1(dec_use_sr1), .dec_use_sr2(dec_use_sr2), .dec_dr(dec_dr),
        .dec_ld_reg(dec_ld_reg), .dec_ld_cc(dec_ld_cc), .dec_use_cc(dec_use_cc),
        .wb_valid(wb_valid), .wb_dest_reg(wb_dest_reg), .wb_reg_data(wb_reg_data),
        .wb_ld_reg(wb_ld_reg), .wb_ld_cc(wb_ld_cc), .wb_nzp(wb_nzp),
        .sr1_data(sr1_data), .sr2_data(sr2_data), .nzp_out(nzp_out),
        .dec_stall(dec_stall), .issue(issue), .sb_err(sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [2:0] dr;
        bit         ld_reg;
        bit         ld_cc;
    } infl_t;

    logic [15:0] m_regs [8];
    int          m_cnt  [8];
    logic [2:0]  m_cc;
    int          m_cccnt;
    bit          m_err;
    bit          model_ok = 1'b0;
    infl_t       inflight [$];

    function automatic int after_commit(int c, bit committing);
        int r;
        r = committing ? c - 1 : c;
        return (r < 0) ? 0 : r;
    endfunction

    function automatic bit model_stall();
        bit h;
        bit cr1, cr2;
        cr1 = wb_valid && wb_ld_reg && (wb_dest_reg == dec_sr1);
        cr2 = wb_valid && wb_ld_reg && (wb_dest_reg == dec_sr2);
        h = (dec_use_sr1 && after_commit(m_cnt[dec_sr1], cr1) > 0) ||
            (dec_use_sr2 && after_commit(m_cnt[dec_sr2], cr2) > 0) ||
            (dec_use_cc  && after_commit(m_cccnt, wb_valid && wb_ld_cc) > 0) ||
            (dec_ld_reg  && m_cnt[dec_dr] == 3) ||
            (dec_ld_cc   && m_cccnt == 3);
        return dec_valid && h;
    endfunction

    function automatic int next_count(int c, bit inc, bit dc);
        if (inc && dc) return c;
        if (dc)        return (c > 0) ? c - 1 : 0;
        if (inc)       return (c < 3) ? c + 1 : 3;
        return c;
    endfunction

    // Model state advances on the same edge as the DUT.
    always @(posedge clk) begin
        automatic bit iss = dec_valid && !model_stall();
        automatic bit e   = 1'b0;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                m_regs[i] <= 16'h0000;
                m_cnt[i]  <= 0;
            end
            m_cc     <= 3'b010;
            m_cccnt  <= 0;
            m_err    <= 1'b0;
            model_ok <= 1'b1;
            inflight.delete();
        end else begin
            for (int i = 0; i < 8; i++) begin
                automatic bit inc = iss && dec_ld_reg && (dec_dr == 3'(i));
                automatic bit dc  = wb_valid && wb_ld_reg && (wb_dest_reg == 3'(i));
                if (dc && m_cnt[i] == 0) e = 1'b1;
                m_cnt[i] <= next_count(m_cnt[i], inc, dc);
            end
            if (wb_valid && wb_ld_cc && m_cccnt == 0) e = 1'b1;
            m_cccnt <= next_count(m_cccnt, iss && dec_ld_cc, wb_valid && wb_ld_cc);
            if (wb_valid && wb_ld_reg) m_regs[wb_dest_reg] <= wb_reg_data;
            if (wb_valid && wb_ld_cc)  m_cc <= wb_nzp;
            m_err <= m_err || e;
            if (iss && (dec_ld_reg || dec_ld_cc))
                inflight.push_back('{dr: dec_dr, ld_reg: dec_ld_reg, ld_cc: dec_ld_cc});
        end
    end

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (model_ok) begin
            automatic bit st = model_stall();
            cmp("m_sr1", sr1_data, (wb_valid && wb_ld_reg && wb_dest_reg == dec_sr1) ?
                                   wb_reg_data : m_regs[dec_sr1]);
            cmp("m_sr2", sr2_data, (wb_valid && wb_ld_reg && wb_dest_reg == dec_sr2) ?
                                   wb_reg_data : m_regs[dec_sr2]);
            cmp("m_nzp", 16'(nzp_out), 16'((wb_valid && wb_ld_cc) ? wb_nzp : m_cc));
            cmp("m_stall", 16'(dec_stall), 16'(st));
            cmp("m_issue", 16'(issue), 16'(dec_valid && !st));
            cmp("m_sb_err", 16'(sb_err), 16'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        rst_n = 1'b1;
        dec_valid = 1'b0; dec_sr1 = 3'd0; dec_sr2 = 3'd0; dec_use_sr1 = 1'b0; dec_use_sr2 = 1'b0;
        dec_dr = 3'd0; dec_ld_reg = 1'b0; dec_ld_cc = 1'b0; dec_use_cc = 1'b0;
        wb_valid = 1'b0; wb_dest_reg = 3'd0; wb_reg_data = 16'h0000;
        wb_ld_reg = 1'b0; wb_ld_cc = 1'b0; wb_nzp = 3'd0;
    endtask

    task automatic step();
        @(posedge clk); #1;
        idle();
    endtask

    task automatic wr_issue(input logic [2:0] r);
        dec_valid = 1'b1; dec_dr = r; dec_ld_reg = 1'b1;
    endtask

    task automatic commit(input logic [2:0] r, input logic [15:0] d);
        wb_valid = 1'b1; wb_dest_reg = r; wb_reg_data = d; wb_ld_reg = 1'b1;
    endtask

    initial begin
        infl_t it;
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1; idle();

        // Reset state reads
        dec_valid = 1'b1; dec_sr1 = 3'd3; dec_sr2 = 3'd5; dec_use_sr1 = 1'b1; dec_use_sr2 = 1'b1;
        @(negedge clk);
        cmp("rst_sr1", sr1_data, 16'h0000);
        cmp("rst_sr2", sr2_data, 16'h0000);
        cmp("rst_nzp", 16'(nzp_out), 16'h0002);
        cmp("rst_stall", 16'(dec_stall), 16'h0000);
        step();

        // RAW hazard on R2 resolved by same-cycle commit
        wr_issue(3'd2); step();
        dec_valid = 1'b1; dec_sr1 = 3'd2; dec_use_sr1 = 1'b1;
        #2 cmp("raw_stall", 16'(dec_stall), 16'h0001);
        commit(3'd2, 16'h1234);
        @(negedge clk);
        cmp("byp_stall", 16'(dec_stall), 16'h0000);
        cmp("byp_sr1", sr1_data, 16'h1234);
        step();

        // Counter saturation on R4
        repeat (3) begin
            wr_issue(3'd4);
            @(negedge clk); cmp("r4_issue", 16'(issue), 16'h0001);
            step();
        end
        wr_issue(3'd4);
        @(negedge clk);
        cmp("sat_stall", 16'(dec_stall), 16'h0001);
        cmp("sat_issue", 16'(issue), 16'h0000);
        step();
        wr_issue(3'd4); commit(3'd4, 16'h0044);
        @(negedge clk); cmp("sat_commit_issue", 16'(issue), 16'h0000);
        step();
        wr_issue(3'd4);
        @(negedge clk); cmp("sat_reissue", 16'(issue), 16'h0001);
        step();
        wr_issue(3'd4);
        @(negedge clk); cmp("sat_again", 16'(dec_stall), 16'h0001);
        step();
        repeat (3) begin commit(3'd4, 16'h0444); step(); end
        dec_valid = 1'b1; dec_sr1 = 3'd4; dec_use_sr1 = 1'b1;
        @(negedge clk); cmp("r4_drained", 16'(dec_stall), 16'h0000);
        step();

        // Simultaneous inc and dec on R1
        wr_issue(3'd1); step();
        wr_issue(3'd1); commit(3'd1, 16'hBEEF); step();
        dec_valid = 1'b1; dec_sr1 = 3'd1; dec_use_sr1 = 1'b1;
        #2 cmp("r1_still1", 16'(dec_stall), 16'h0001);
        cmp("r1_data", sr1_data, 16'hBEEF);
        commit(3'd1, 16'h5555);
        @(negedge clk);
        cmp("r1_free", 16'(dec_stall), 16'h0000);
        cmp("r1_byp", sr1_data, 16'h5555);
        step();

        // Underflow on R6
        commit(3'd6, 16'h0666); step();
        dec_valid = 1'b1; dec_sr1 = 3'd6; dec_use_sr1 = 1'b1;
        @(negedge clk);
        cmp("uf_err", 16'(sb_err), 16'h0001);
        cmp("uf_cnt0", 16'(dec_stall), 16'h0000);
        step();
        repeat (3) step();
        @(negedge clk); cmp("uf_sticky", 16'(sb_err), 16'h0001);
        rst_n = 1'b0; step();
        dec_sr1 = 3'd2;
        @(negedge clk);
        cmp("uf_clear", 16'(sb_err), 16'h0000);
        cmp("rst_r2", sr1_data, 16'h0000);
        step();

        // CC hazard and bypass
        dec_valid = 1'b1; dec_ld_cc = 1'b1; step();
        dec_valid = 1'b1; dec_use_cc = 1'b1;
        #2 cmp("cc_stall", 16'(dec_stall), 16'h0001);
        wb_valid = 1'b1; wb_ld_cc = 1'b1; wb_nzp = 3'b100;
        @(negedge clk);
        cmp("cc_byp", 16'(nzp_out), 16'h0004);
        cmp("cc_free", 16'(dec_stall), 16'h0000);
        step();
        @(negedge clk); cmp("cc_held", 16'(nzp_out), 16'h0004);
        step();

        // Reset mid-operation abandons pending R7
        wr_issue(3'd7); step();
        wr_issue(3'd7); commit(3'd7, 16'h7777); rst_n = 1'b0; step();
        dec_valid = 1'b1; dec_sr1 = 3'd7; dec_use_sr1 = 1'b1;
        @(negedge clk);
        cmp("midrst_stall", 16'(dec_stall), 16'h0000);
        cmp("midrst_r7", sr1_data, 16'h0000);
        step();

        // Randomized pipeline traffic
        rst_n = 1'b0; step();
        for (int n = 0; n < 3000; n++) begin
            rst_n       = ($urandom_range(0, 299) != 0);
            dec_valid   = ($urandom_range(0, 3) != 0);
            dec_sr1     = 3'($urandom_range(0, 7));
            dec_sr2     = 3'($urandom_range(0, 7));
            dec_use_sr1 = 1'($urandom_range(0, 1));
            dec_use_sr2 = 1'($urandom_range(0, 1));
            dec_use_cc  = ($urandom_range(0, 3) == 0);
            dec_dr      = 3'($urandom_range(0, 3));
            dec_ld_reg  = ($urandom_range(0, 3) != 0);
            dec_ld_cc   = 1'($urandom_range(0, 1));
            wb_reg_data = 16'($urandom);
            case ($urandom_range(0, 2))
                0:       wb_nzp = 3'b100;
                1:       wb_nzp = 3'b010;
                default: wb_nzp = 3'b001;
            endcase
            if (inflight.size() > 0 && $urandom_range(0, 2) != 0) begin
                it = inflight.pop_front();
                wb_valid = 1'b1; wb_dest_reg = it.dr;
                wb_ld_reg = it.ld_reg; wb_ld_cc = it.ld_cc;
            end else begin
                wb_valid    = 1'b0;
                wb_dest_reg = 3'($urandom_range(0, 7));
                wb_ld_reg   = 1'($urandom_range(0, 1));
                wb_ld_cc    = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
        end
        idle();
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
